// File: rtl/pll_spi_pkg.sv
// Shared types and widths for the PLL SPI arbiter.
// Holds the FSM encoding, SPI field widths and a counter-width helper.
package pll_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT,
        RESP
    } state_t;

    localparam int SPI_ADDR_W = 8;
    localparam int SPI_DATA_W = 8;

    // Width of a counter that must hold 0..n-1 ($clog2, never below 1).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pll_spi_rr_pick.sv
// Combinational round-robin selector.
// Ports: req (request vector), last (last served) -> any, win (next winner).
module pll_spi_rr_pick #(
    parameter  int N_REQ = 2,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic             any,
    output logic [IW-1:0]    win
);

    int j;

    // Walk from the farthest candidate to the nearest one so the
    // nearest set bit after last is the one left in win.
    always_comb begin
        any = 1'b0;
        win = '0;
        j   = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j = int'(last) + 1 + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (req[IW'(j)]) begin
                any = 1'b1;
                win = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pll_spi_arbiter.sv
// Round-robin arbiter sharing one PLL SPI engine among N_REQ requesters,
// with a watchdog that resets a hung engine and returns an error response.
// Ports: clk/reset; req/rd/addr/wdata in, gnt/rsp_* out per requester;
// busy, timeout_count status; if_* drive the SPI engine.
module pll_spi_arbiter
    import pll_spi_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int RST_CYCLES     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            rd,
    input  logic [SPI_ADDR_W*N_REQ-1:0] addr,
    input  logic [SPI_DATA_W*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [SPI_DATA_W-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [7:0]                  timeout_count,
    output logic                        if_read,
    output logic                        if_write,
    output logic [SPI_ADDR_W-1:0]       if_addr,
    output logic [SPI_DATA_W-1:0]       if_wdata,
    input  logic [SPI_DATA_W-1:0]       if_rdata,
    input  logic                        if_done,
    output logic                        if_reset
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = cnt_w(TIMEOUT_CYCLES);
    localparam int RW = cnt_w(RST_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_LOAD = RW'(RST_CYCLES - 1);

    state_t                  state, state_d;
    logic [IW-1:0]           last, last_d, w, w_d, win;
    logic [TW-1:0]           timer, timer_d;
    logic [RW-1:0]           rcnt, rcnt_d;
    logic [N_REQ-1:0]        gnt_d, rv_d;
    logic [SPI_DATA_W-1:0]   rdata_d, wdata_d;
    logic [SPI_ADDR_W-1:0]   addr_d;
    logic [7:0]              tc_d;
    logic                    err_d, rd_d, wr_d, ifrst_d, busy_d, any;
    logic [SPI_ADDR_W-1:0]   addr_a  [N_REQ];
    logic [SPI_DATA_W-1:0]   wdata_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign addr_a[g]  = addr[g*SPI_ADDR_W +: SPI_ADDR_W];
        assign wdata_a[g] = wdata[g*SPI_DATA_W +: SPI_DATA_W];
    end

    pll_spi_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (req),
        .last (last),
        .any  (any),
        .win  (win)
    );

    always_comb begin
        state_d = state;
        last_d  = last;
        w_d     = w;
        timer_d = timer;
        rcnt_d  = rcnt;
        gnt_d   = gnt;
        rv_d    = rsp_valid;
        rdata_d = rsp_rdata;
        err_d   = rsp_err;
        tc_d    = timeout_count;
        rd_d    = if_read;
        wr_d    = if_write;
        addr_d  = if_addr;
        wdata_d = if_wdata;
        ifrst_d = if_reset;
        unique case (state)
            IDLE: begin
                // Releases the engine on the first edge after block reset.
                ifrst_d = 1'b1;
                if (any) begin
                    w_d        = win;
                    addr_d     = addr_a[win];
                    wdata_d    = wdata_a[win];
                    rd_d       = rd[win];
                    wr_d       = !rd[win];
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    timer_d    = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                timer_d = timer + 1'b1;
                // Completion takes priority over a same-cycle timeout.
                if (if_done) begin
                    rdata_d  = if_read ? if_rdata : '0;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    rv_d[w]  = 1'b1;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (timer == T_LAST) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ifrst_d = 1'b0;
                    rcnt_d  = R_LOAD;
                    if (timeout_count != 8'hFF) tc_d = timeout_count + 8'd1;
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (rcnt == '0) begin
                    ifrst_d = 1'b1;
                    rv_d[w] = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    rcnt_d = rcnt - 1'b1;
                end
            end
            RESP: begin
                rv_d    = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                gnt_d   = '0;
                last_d  = w;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last          <= IW'(N_REQ - 1);
            w             <= '0;
            timer         <= '0;
            rcnt          <= '0;
            gnt           <= '0;
            rsp_valid     <= '0;
            rsp_rdata     <= '0;
            rsp_err       <= 1'b0;
            busy          <= 1'b0;
            timeout_count <= '0;
            if_read       <= 1'b0;
            if_write      <= 1'b0;
            if_addr       <= '0;
            if_wdata      <= '0;
            if_reset      <= 1'b0;
        end else begin
            state         <= state_d;
            last          <= last_d;
            w             <= w_d;
            timer         <= timer_d;
            rcnt          <= rcnt_d;
            gnt           <= gnt_d;
            rsp_valid     <= rv_d;
            rsp_rdata     <= rdata_d;
            rsp_err       <= err_d;
            busy          <= busy_d;
            timeout_count <= tc_d;
            if_read       <= rd_d;
            if_write      <= wr_d;
            if_addr       <= addr_d;
            if_wdata      <= wdata_d;
            if_reset      <= ifrst_d;
        end
    end

endmodule

// File: tb/tb_pll_spi_arbiter.sv
// Scoreboard bench for pll_spi_arbiter: engine model predicts each response,
// a separate monitor pops and checks it when rsp_valid pulses.
module tb_pll_spi_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;
    localparam int RC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req, rd;
    logic [8*N-1:0] addr, wdata;
    logic [N-1:0] gnt, rsp_valid;
    logic [7:0]   rsp_rdata, timeout_count, if_addr, if_wdata;
    logic         rsp_err, busy, if_read, if_write, if_reset;
    logic [7:0]   if_rdata = 8'h00;
    logic         if_done  = 1'b0;

    always #5 clk = ~clk;

    pll_spi_arbiter #(
        .N_REQ(N), .TIMEOUT_CYCLES(TO), .RST_CYCLES(RC)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .rd(rd), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .timeout_count(timeout_count), .if_read(if_read),
        .if_write(if_write), .if_addr(if_addr), .if_wdata(if_wdata),
        .if_rdata(if_rdata), .if_done(if_done), .if_reset(if_reset)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] data;
        logic       err;
        logic [7:0] tc;
    } rsp_t;

    rsp_t       sbq[$];
    rsp_t       e;
    int         dscr[$];
    logic [7:0] dat_scr[$];

    int cyc = 0;
    int raise_cyc[N];
    bit lat_chk = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;

    // Spec rule: first pending requester after the last one served.
    function automatic int pick(input logic [N-1:0] r, input int lst);
        for (int k = 1; k <= N; k++)
            if (r[(lst + k) % N]) return (lst + k) % N;
        return -1;
    endfunction

    // Engine model. e_d = cycle (0 = issue cycle) in which if_done is
    // sampled; -1 means the engine never answers.
    bit         e_act = 1'b0;
    int         e_c, e_d, e_id, m_last, r;
    logic       e_rd;
    logic [7:0] m_tc;
    logic [N-1:0] req_prev = '0;

    always @(negedge clk) begin
        if (!reset) begin
            e_act   = 1'b0;
            if_done = 1'b0;
            m_last  = N - 1;
            m_tc    = 8'h00;
        end else if (!e_act) begin
            if (if_read || if_write) begin
                e_id = pick(req_prev, m_last);
                if (e_id < 0) begin
                    chk("issue_with_req", 0, 1);
                    e_id = 0;
                end
                m_last = e_id;
                e_rd   = rd[e_id];
                chk("issue_gnt", gnt, 64'(1 << e_id));
                chk("issue_rd", {if_read, if_write}, {e_rd, !e_rd});
                chk("issue_addr", if_addr, addr[e_id*8 +: 8]);
                chk("issue_wdata", if_wdata, wdata[e_id*8 +: 8]);
                chk("issue_busy", busy, 1);
                if (lat_chk) chk("issue_latency", cyc, raise_cyc[e_id] + 1);
                if (dscr.size() > 0) begin
                    e_d      = dscr.pop_front();
                    if_rdata = dat_scr.pop_front();
                end else begin
                    r = $urandom_range(0, 9);
                    e_d = (r == 0) ? -1 : (r == 1) ? TO - 1 :
                          (r == 2) ? 0 : $urandom_range(1, TO - 2);
                    if_rdata = 8'($urandom);
                end
                if (e_d < 0 && m_tc != 8'hFF) m_tc++;
                sbq.push_back('{e_id, (e_d >= 0 && e_rd) ? if_rdata : 8'h00,
                                e_d < 0, m_tc});
                e_c     = 0;
                e_act   = 1'b1;
                if_done = (e_d == 0);
            end
        end else begin
            e_c++;
            if (e_d < 0) begin
                chk("abort_if_reset", if_reset, !(e_c >= TO && e_c < TO + RC));
                if (e_c < TO) chk("abort_cmd_held", {if_read, if_write}, {e_rd, !e_rd});
                else          chk("abort_cmd_off", {if_read, if_write}, 0);
                if (e_c == TO + RC) e_act = 1'b0;
            end else begin
                chk("done_if_reset", if_reset, 1);
                if (e_c <= e_d) chk("done_cmd_held", {if_read, if_write}, {e_rd, !e_rd});
                else            chk("done_cmd_off", {if_read, if_write}, 0);
                if (e_c == e_d)          if_done = 1'b1;
                else if (e_c == e_d + 1) if_done = ($urandom_range(0, 3) == 0);
                else                     if_done = 1'b0;
                if (e_c == e_d + 2) e_act = 1'b0;
            end
        end
        req_prev = req;
    end

    // Response monitor.
    always @(negedge clk) begin
        if (!reset) begin
            sbq.delete();
        end else begin
            chk("gnt_onehot0", $onehot0(gnt), 1);
            if (rsp_valid != '0) begin
                if (sbq.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_valid", rsp_valid, 64'(1 << e.id));
                    chk("rsp_gnt", gnt, 64'(1 << e.id));
                    chk("rsp_rdata", rsp_rdata, e.data);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_tcount", timeout_count, e.tc);
                end
            end
        end
    end

    task automatic do_req(input int i, input logic r_rd,
                          input logic [7:0] a, input logic [7:0] wd);
        int t;
        @(posedge clk); #1;
        rd[i]           = r_rd;
        addr[i*8 +: 8]  = a;
        wdata[i*8 +: 8] = wd;
        req[i]          = 1'b1;
        raise_cyc[i]    = cyc;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!rsp_valid[i] && t < 300);
        chk($sformatf("req%0d_answered", i), rsp_valid[i], 1);
        @(posedge clk); #1;
        req[i] = 1'b0;
    endtask

    initial begin
        int t;
        reset = 1'b0;
        req   = '0;
        rd    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs_a", {gnt, rsp_valid, rsp_rdata, rsp_err, busy}, 0);
        chk("rst_outs_b", {timeout_count, if_read, if_write, if_addr, if_wdata}, 0);
        chk("rst_if_reset", if_reset, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_if_reset_hold", if_reset, 0);
        @(negedge clk);
        chk("rel_if_reset_up", if_reset, 1);

        lat_chk = 1'b1;
        dscr.push_back(10);     dat_scr.push_back(8'h5A);
        do_req(0, 1'b0, 8'h01, 8'h01);
        dscr.push_back(6);      dat_scr.push_back(8'hFF);
        do_req(1, 1'b1, 8'h02, 8'h00);
        dscr.push_back(-1);     dat_scr.push_back(8'h77);
        do_req(0, 1'b1, 8'h10, 8'h00);
        dscr.push_back(TO - 1); dat_scr.push_back(8'hC3);
        do_req(1, 1'b1, 8'h20, 8'h00);
        dscr.push_back(3);      dat_scr.push_back(8'h11);
        do_req(0, 1'b0, 8'h30, 8'hA5);
        lat_chk = 1'b0;

        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    do_req(0, 1'($urandom), 8'($urandom), 8'($urandom));
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    do_req(1, 1'($urandom), 8'($urandom), 8'($urandom));
                end
            end
        join

        @(posedge clk); #1;
        dscr.push_back(14); dat_scr.push_back(8'h00);
        rd[1] = 1'b0;
        addr[15:8] = 8'h33;
        req[1] = 1'b1;
        t = 0;
        while (!gnt[1] && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("midrst_granted", gnt[1], 1);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_outs_a", {gnt, rsp_valid, rsp_rdata, rsp_err, busy}, 0);
        chk("midrst_outs_b", {timeout_count, if_read, if_write, if_addr, if_wdata}, 0);
        chk("midrst_if_reset", if_reset, 0);
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        fork
            do_req(0, 1'b1, 8'h44, 8'h00);
            do_req(1, 1'b0, 8'h55, 8'h66);
        join
        repeat (5) @(posedge clk);
        chk("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
